mmio_uart: RTL and testbench
============================

# mmio_uart

Memory-mapped UART peripheral with configurable-depth TX and RX FIFOs, a software-programmable baud divisor, sticky error flags and a level interrupt. It sits on the core's data bus beside data memory and GPIO, and replaces single-byte holding registers with buffered 8N1 serial I/O. Register reads are combinational, and the block contains its own transmit and receive engines.

## Interface
- `DEPTH`, 16: entries per FIFO; must be a power of two, 2..128.
- `BASE`, 32'h10010000: bus address of register offset 0x00.
- `DIV_RESET`, 16'd3: reset value of DIVISOR.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `address` in 32: bus byte address.
- `write_data` in 32: bus write data.
- `write_enable` in 1: bus write strobe, one cycle per access.
- `read_enable` in 1: bus read strobe; pops RX data on a DATA read.
- `read_data` out 32: combinational register read value; 0 when the address does not match.
- `tx` out 1: serial output; idles high.
- `rx` in 1: asynchronous serial input.
- `irq` out 1: registered level interrupt.

## Operation
- Decode: a register is selected when `address == BASE + offset`. Other addresses read 0, and writes to them are ignored.
- 0x00 DATA
  - Write pushes `write_data[7:0]` into the TX FIFO. If the FIFO is full, the byte is dropped and TX_OVF is set.
  - Read returns {24'b0, RX head}. With `read_enable`, the head is popped. Reading an empty FIFO returns 0 and does not pop.
- 0x04 STATUS (read)
  - bit0 RX_NE, bit1 RX_FULL, bit2 TX_EMPTY, bit3 TX_FULL, bit4 TX_BUSY.
  - Sticky flags: bit5 RX_OVF, bit6 FRAME_ERR, bit7 TX_OVF.
  - Write: a 1 in bits 7:5 clears the corresponding sticky flag. If a clear and a set occur in the same cycle, the set wins.
- 0x08 DIVISOR: bits [15:0]. A bit period is DIVISOR+1 cycles. A written value of 0 is stored as 1.
- 0x0C CTRL: bit0 RX_IE, bit1 TX_IE.
- 0x10 LEVEL: [23:16] rx_count, [7:0] tx_count. Counts range 0..DEPTH.
- `irq`: registered value of (RX_IE & RX_NE) | (TX_IE & TX_EMPTY & !TX_BUSY).
- FIFO push-when-full: a push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
- TX FSM, states IDLE, START, DATA, STOP
  - IDLE → START when the TX FIFO is non-empty. The FIFO head is popped and loaded into the shift register in that cycle.
  - Each state lasts one bit period. DATA sends 8 bits, LSB first, then moves to STOP.
  - STOP → IDLE. If the FIFO is still non-empty, the next START follows back-to-back.
  - TX_BUSY is asserted whenever the FSM is not in IDLE.
- RX FSM, states IDLE, START, DATA, STOP
  - `rx` passes through a 2-flop synchronizer before the FSM sees it.
  - IDLE → START on a synchronized falling edge.
  - START waits (DIVISOR+1)>>1 cycles, then re-samples. Low → DATA. High → IDLE (false start).
  - DATA samples 8 bits, one every DIVISOR+1 cycles, LSB first.
  - STOP takes one sample:
    - Sample 1: push the byte. If the push fails, set RX_OVF and drop the byte.
    - Sample 0: set FRAME_ERR and discard the byte.
    - In both cases the FSM returns to IDLE immediately after the stop sample, which is mid stop bit.
- DIVISOR changes take effect at the next bit-counter reload. The current bit completes with the old value.

## Timing
- Reset values: `tx`=1, `irq`=0, `read_data` decodes as normal.
  - Both FIFOs empty, all sticky flags 0.
  - DIVISOR=`DIV_RESET`, CTRL=0.
  - Both FSMs in IDLE.
- STATUS reads 0x04 after reset.
- TX latency: a DATA write in cycle t (engine idle) drives `tx` low from cycle t+2.
- Frame length: 10×(DIVISOR+1) cycles.
- RX latency: RX_NE rises 1 cycle after the stop-bit sample.
- A DATA read with `read_enable` returns the pre-pop head in the same cycle; the count updates at the next edge.
- `rst` mid-frame: the frame is aborted, and `tx` is 1 on the cycle after the reset edge.

## Structure
- Package `mmio_uart_pkg` holds:
  - register offset constants;
  - STATUS bit indices;
  - `tx_state_t` and `rx_state_t` enums.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, count) is instantiated twice.
  - Read is first-word fall-through.
  - Pointers wrap modulo DEPTH.

## Test plan
- Reset → STATUS=0x04, DIVISOR=3, LEVEL=0, `tx`=1, `irq`=0.
- DIVISOR=3, write 0xA5 → `tx` low at t+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. TX_BUSY is set for 40 cycles.
- DIVISOR=100, write DEPTH+2 bytes back-to-back:
  - DEPTH+1 bytes are accepted, since the first is popped immediately.
  - The last byte is dropped and STATUS bit7 is set.
  - Writing 0x80 to STATUS clears bit7.
- RX frame 0x3C at DIVISOR=3 with RX_IE=1 → RX_NE=1 and `irq`=1. A DATA read returns 0x3C, then RX_NE=0 and `irq` falls.
- RX frame with stop bit 0 → FRAME_ERR=1, LEVEL rx_count=0. A one-cycle low glitch on `rx` → no push, no flags.
- DEPTH+1 RX frames without reads → RX_FULL=1 and RX_OVF=1. Reads return the first DEPTH bytes in order.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
package mmio_uart_pkg;

  // Register offsets relative to BASE
  localparam logic [31:0] OFF_DATA    = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_DIVISOR = 32'h08;
  localparam logic [31:0] OFF_CTRL    = 32'h0C;
  localparam logic [31:0] OFF_LEVEL   = 32'h10;

  // STATUS bit positions
  localparam int unsigned ST_RX_NE     = 0;
  localparam int unsigned ST_RX_FULL   = 1;
  localparam int unsigned ST_TX_EMPTY  = 2;
  localparam int unsigned ST_TX_FULL   = 3;
  localparam int unsigned ST_TX_BUSY   = 4;
  localparam int unsigned ST_RX_OVF    = 5;
  localparam int unsigned ST_FRAME_ERR = 6;
  localparam int unsigned ST_TX_OVF    = 7;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; occupancy is tracked by count_q, so stale words are never observed.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: register file, TX/RX FIFOs, TX and RX engines.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE      = 32'h1001_0000,
  parameter logic [15:0] DIV_RESET = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic sel_data, sel_status, sel_div, sel_ctrl, sel_level;
  assign sel_data   = (address == BASE + OFF_DATA);
  assign sel_status = (address == BASE + OFF_STATUS);
  assign sel_div    = (address == BASE + OFF_DIVISOR);
  assign sel_ctrl   = (address == BASE + OFF_CTRL);
  assign sel_level  = (address == BASE + OFF_LEVEL);

  logic unused_wdata;
  assign unused_wdata = ^write_data[31:16];

  logic [15:0] div_q;
  logic [1:0]  ctrl_q;
  logic        rx_ovf_q, frame_err_q, tx_ovf_q, irq_q;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count;

  assign tx_push = write_enable & sel_data;
  assign rx_pop  = read_enable & sel_data & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(write_data[7:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  logic [7:0] rx_shift_q, rx_shift_d;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_d),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- TX engine ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_busy;

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx      = tx_q;

  // TX next-state: each state lasts DIVISOR+1 cycles; STOP chains straight into the next START.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_shift_d = tx_rdata; tx_cnt_d = div_q; tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_cnt_d = div_q; tx_bit_d = '0; tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d   = div_q;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        else                  tx_bit_d   = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
      TX_STOP: if (tx_cnt_q == '0) begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_rdata; tx_cnt_d = div_q; tx_state_d = TX_START;
        end else tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state to keep the pin glitch-free.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0; tx_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d; tx_q <= tx_d;
    end
  end

  // ---------------- RX engine ----------------
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half_m1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, frame_err_set;

  // Half a bit period minus one: (DIVISOR+1)>>1 cycles spent in START before re-sampling.
  assign rx_half_m1 = (div_q >> 1) + {15'd0, div_q[0]} - 16'd1;

  // RX next-state: mid-bit sampling driven by the synchronized line.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_cnt_d = rx_half_m1; rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (!rx_sync_q) begin rx_cnt_d = div_q; rx_bit_d = '0; rx_state_d = RX_DATA; end
        else rx_state_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_cnt_d   = div_q;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      RX_STOP: if (rx_cnt_q == '0) begin
        if (rx_sync_q) rx_push = 1'b1;
        else           frame_err_set = 1'b1;
        rx_state_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX synchronizer and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
    end else begin
      rx_meta_q <= rx; rx_sync_q <= rx_meta_q; rx_prev_q <= rx_sync_q;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- Registers, flags, interrupt ----------------
  logic [2:0] clr;
  assign clr = (write_enable & sel_status) ?
               {write_data[ST_TX_OVF], write_data[ST_FRAME_ERR], write_data[ST_RX_OVF]} : 3'b000;

  // Control registers, sticky flags (set beats clear) and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RESET; ctrl_q <= '0;
      rx_ovf_q <= 1'b0; frame_err_q <= 1'b0; tx_ovf_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      if (write_enable && sel_div)
        div_q <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
      if (write_enable && sel_ctrl) ctrl_q <= write_data[1:0];
      rx_ovf_q    <= (rx_ovf_q & ~clr[0]) | (rx_push & rx_full & ~rx_pop);
      frame_err_q <= (frame_err_q & ~clr[1]) | frame_err_set;
      tx_ovf_q    <= (tx_ovf_q & ~clr[2]) | (tx_push & tx_full & ~tx_pop);
      irq_q       <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);
    end
  end
  assign irq = irq_q;

  logic [7:0]  status;
  logic [31:0] level;

  // Combinational register read mux.
  always_comb begin
    status               = '0;
    status[ST_RX_NE]     = ~rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_RX_OVF]    = rx_ovf_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_OVF]    = tx_ovf_q;
    level                = '0;
    level[16 +: CW]      = rx_count;
    level[0 +: CW]       = tx_count;
    read_data            = '0;
    if (sel_data)        read_data = {24'd0, rx_empty ? 8'd0 : rx_rdata};
    else if (sel_status) read_data = {24'd0, status};
    else if (sel_div)    read_data = {16'd0, div_q};
    else if (sel_ctrl)   read_data = {30'd0, ctrl_q};
    else if (sel_level)  read_data = level;
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart.
module tb_mmio_uart;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h1001_0000;
  localparam logic [31:0] A_DATA   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_DIV    = BASE + 32'h08;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0C;
  localparam logic [31:0] A_LEVEL  = BASE + 32'h10;
  localparam int          RX_DIV   = 3;

  logic        clk = 1'b0;
  logic        rst, write_enable, read_enable, rx;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        tx, irq;

  int checks = 0;
  int errors = 0;

  mmio_uart #(.DEPTH(DEPTH), .BASE(BASE), .DIV_RESET(16'd3)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
    .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0; address = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read_enable = 1'b1;
    #1 d = read_data;
    @(negedge clk);
    read_enable = 1'b0; address = 32'h0;
  endtask

  // Drives one 8N1 frame at RX_DIV, then idles high and lets the receiver settle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c <= RX_DIV; c++) begin
        @(negedge clk);
        rx = bits[i];
      end
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  tx_byte;
    logic [31:0] exp_tx;
    logic        drained;
    logic [7:0]  rx_bytes [DEPTH+1];

    rst = 1'b1; address = '0; write_data = '0; write_enable = 1'b0; read_enable = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    bus_read(A_STATUS, d); check("reset_status", d, 32'h04);
    bus_read(A_DIV, d);    check("reset_divisor", d, 32'd3);
    bus_read(A_LEVEL, d);  check("reset_level", d, 32'h0);
    bus_read(A_CTRL, d);   check("reset_ctrl", d, 32'h0);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(BASE + 32'h20, d); check("unmapped_read", d, 32'h0);

    // Divisor 0 is stored as 1
    bus_write(A_DIV, 32'h0);
    bus_read(A_DIV, d); check("div_zero_to_one", d, 32'd1);
    bus_write(A_DIV, 32'd3);
    bus_read(A_DIV, d); check("div_three", d, 32'd3);

    // Single frame 0xA5 at DIVISOR=3: tx low from t+2, 40 busy cycles
    tx_byte = 8'hA5;
    bus_write(A_DATA, 32'hA5);
    address = A_STATUS;
    #1 check("tx_t1_still_high", {31'd0, tx}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (k < 4)       exp_tx = 32'd0;
      else if (k < 36) exp_tx = {31'd0, tx_byte[(k-4)/4]};
      else             exp_tx = 32'd1;
      check($sformatf("tx_line_c%0d", k), {31'd0, tx}, exp_tx);
      check($sformatf("tx_busy_c%0d", k), {31'd0, read_data[4]}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("tx_after_frame_line", {31'd0, tx}, 32'd1);
    check("tx_after_frame_status", read_data, 32'h04);
    address = 32'h0;

    // TX overflow: DEPTH+2 back-to-back writes at a slow divisor
    bus_write(A_DIV, 32'd100);
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      address = A_DATA; write_data = 32'(i + 8'h30); write_enable = 1'b1;
    end
    @(negedge clk);
    write_enable = 1'b0; address = 32'h0;
    bus_read(A_STATUS, d); check("tx_ovf_status", d, 32'h98);
    bus_read(A_LEVEL, d);  check("tx_ovf_level", d, 32'h10);
    bus_write(A_STATUS, 32'h80);
    bus_read(A_STATUS, d); check("tx_ovf_cleared", d, 32'h18);

    // Speed up and drain; the new divisor applies from the next bit reload
    bus_write(A_DIV, 32'd3);
    address = A_STATUS;
    drained = 1'b0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      @(negedge clk);
      #1 if (read_data == 32'h04) drained = 1'b1;
    end
    address = 32'h0;
    check("tx_drain_done", {31'd0, drained}, 32'd1);
    bus_read(A_LEVEL, d); check("tx_drain_level", d, 32'h0);

    // TX_IE interrupt when transmitter idle and empty
    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    check("irq_tx_ie", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    check("irq_rx_ie_empty", {31'd0, irq}, 32'd0);

    // RX frame 0x3C with RX_IE
    send_frame(8'h3C, 1'b1);
    bus_read(A_STATUS, d); check("rx_ne_status", d, 32'h05);
    check("rx_irq_high", {31'd0, irq}, 32'd1);
    bus_read(A_LEVEL, d);  check("rx_level_one", d, 32'h0001_0000);
    bus_read(A_DATA, d);   check("rx_data_3c", d, 32'h3C);
    bus_read(A_STATUS, d); check("rx_status_after_pop", d, 32'h04);
    check("rx_irq_low", {31'd0, irq}, 32'd0);

    // Framing error: byte discarded
    send_frame(8'h55, 1'b0);
    bus_read(A_STATUS, d); check("frame_err_status", d, 32'h44);
    bus_read(A_LEVEL, d);  check("frame_err_level", d, 32'h0);
    bus_write(A_STATUS, 32'h40);
    bus_read(A_STATUS, d); check("frame_err_cleared", d, 32'h04);

    // One-cycle glitch: false start, nothing recorded
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (12) @(negedge clk);
    bus_read(A_STATUS, d); check("glitch_status", d, 32'h04);
    bus_read(A_LEVEL, d);  check("glitch_level", d, 32'h0);

    // RX overflow: DEPTH+1 frames with no reads
    for (int i = 0; i <= DEPTH; i++) begin
      rx_bytes[i] = 8'(i * 13 + 5);
      send_frame(rx_bytes[i], 1'b1);
    end
    bus_read(A_STATUS, d); check("rx_ovf_status", d, 32'h27);
    bus_read(A_LEVEL, d);  check("rx_ovf_level", d, 32'h0010_0000);
    check("rx_ovf_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(A_DATA, d);
      check($sformatf("rx_order_%0d", i), d, {24'd0, rx_bytes[i]});
    end
    bus_read(A_STATUS, d); check("rx_drained_status", d, 32'h24);
    bus_read(A_DATA, d);   check("rx_empty_read", d, 32'h0);
    bus_read(A_LEVEL, d);  check("rx_empty_level", d, 32'h0);
    check("rx_drained_irq", {31'd0, irq}, 32'd0);
    bus_write(A_STATUS, 32'h20);
    bus_read(A_STATUS, d); check("rx_ovf_cleared", d, 32'h04);

    // Reset mid-frame aborts transmission and restores registers
    bus_write(A_DIV, 32'd7);
    bus_write(A_DATA, 32'h00);
    repeat (20) @(negedge clk);
    check("midframe_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    bus_read(A_STATUS, d); check("midframe_reset_status", d, 32'h04);
    bus_read(A_DIV, d);    check("midframe_reset_div", d, 32'd3);
    check("midframe_reset_irq", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
